fpalu_add_pipe: RTL and testbench
=================================

Name: fpalu_add_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle IEEE-754 adder.
- Performs add or subtract on two floating-point operands of configurable exponent/mantissa width.
- Fixed 3-stage pipeline with valid/ready handshakes on input and output.
- Sits between the operand issue logic and the FPALU result mux. Adds round-to-nearest-even and full special-case flags.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa (fraction) width; total word W = 1+EXP_W+MAN_W

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  1: compute a-b; 0: compute a+b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  W  result
- overflow  output  1  finite inputs produced ±inf
- underflow  output  1  nonzero exact result flushed to zero
- invalid  output  1  NaN result (NaN input or inf-inf)

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, s, overflow, underflow and invalid are 0. Reset mid-operation discards all in-flight results; nothing is emitted after release until new input.
- Global stall: en = !out_valid || out_ready. in_ready = en (combinational). All stages advance only when en=1. Bubbles are not compressed.
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Latency: 3 cycles from accepted input to out_valid with no stall. Throughput is 1 per cycle.
- While out_valid=1 and out_ready=0, s and all flags are held stable.
- Stage 1 (unpack/align):
  - Effective b sign = b.sign ^ sub.
  - Exponent field 0 is treated as zero: denormal inputs flush to ±0.
  - Classify zero/inf/NaN.
  - Swap so the larger-magnitude operand is first.
  - Right-shift the smaller significand (hidden bit included) by the exponent difference, keeping guard, round and sticky bits.
  - A shift of MAN_W+3 or more leaves only sticky.
- Stage 2 (add): add or subtract the significands, MAN_W+5 bits wide. Result sign is the sign of the larger operand.
- Stage 3 (normalise/round):
  - Normalise by a carry-out right shift or a leading-zero left shift, with matching exponent adjust.
  - Round to nearest even.
  - Renormalise if rounding carries out.
- Result rules:
  - Biased exponent >= 2^EXP_W-1 → ±inf, overflow=1.
  - Biased exponent <= 0 with nonzero value → ±0, underflow=1.
  - Exact cancellation → +0.
  - (-0)+(-0) → -0.
- Special cases:
  - Any NaN input, or inf + (-inf) after sub adjustment → canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0), invalid=1.
  - inf op finite → that inf, no flags.
- Flags are valid only with out_valid and are mutually exclusive.

Test Plan:
- Basic add, with out_ready=1: a=3F800000, b=3F800000, sub=0 → exactly 3 cycles later out_valid=1, s=40000000, all flags 0.
- Cancellation: a=3FC00000, b=3FC00000, sub=1 → s=00000000. Also a=80000000, b=80000000, sub=0 → s=80000000.
- Round-to-nearest-even: 3F800000+33800000 → 3F800000. 3F800001+33800000 → 3F800002.
- Specials:
  - 7F7FFFFF+7F7FFFFF → s=7F800000, overflow=1.
  - 7F800000+FF800000 → s=7FC00000, invalid=1.
  - 7F800000+3F800000 → 7F800000, no flags.
- Backpressure:
  - Setup: stream 5 back-to-back operand pairs with out_ready=0.
  - During the stall: in_ready drops after 3 accepts and s is held stable.
  - On raising out_ready: results emerge in order with none lost or duplicated.
- Async reset: assert rst_n low mid-stream, asynchronously to clk → out_valid and s go to 0 immediately, with no stale outputs after release. Parameter sweep EXP_W=5, MAN_W=10: 3C00+3C00 → 4000.

Source files
------------

// File: rtl/fpalu_add_pipe.sv
// fpalu_add_pipe: three-stage pipelined IEEE-754 style adder/subtractor.
// Stage 1 unpacks, classifies and aligns; stage 2 adds the significands;
// stage 3 normalises, rounds to nearest even and packs the result.
// A single global enable stalls every stage while the output is held.
module fpalu_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   s,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int AW  = MAN_W + 5;          // SW plus carry-out
    localparam int EW  = EXP_W + 2;          // signed working exponent
    localparam int LZW = $clog2(SW + 1);
    localparam logic [31:0]          SHIFT_MAX = 32'(MAN_W + 3);
    localparam logic signed [EW-1:0] EXP_INF   = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);
    localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);

    // Leading-zero count of a normalisation window; all-zero input returns SW.
    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) begin
                n = LZW'(SW - 1 - i);
            end
        end
        return n;
    endfunction

    logic en_s;

    // Stage 1 working signals
    logic                 a_sign_s, b_sign_s;
    logic [EXP_W-1:0]     a_exp_s, b_exp_s;
    logic [MAN_W-1:0]     a_man_s, b_man_s;
    logic                 a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic [W-2:0]         a_mag_s, b_mag_s;
    logic                 big_sign_s, small_sign_s;
    logic [EXP_W-1:0]     big_exp_s, small_exp_s, shift_s;
    logic [MAN_W:0]       big_sig_s, small_sig_s;
    logic [SW-1:0]        small_full_s, small_al_s;
    logic                 nan_s, inf_s, inf_sign_s, zero_sign_s;

    // Stage 1 registers
    logic                 v1_r, sign1_r, esub1_r, nan1_r, inf1_r, infs1_r, zs1_r;
    logic [EXP_W-1:0]     exp1_r;
    logic [SW-1:0]        big1_r, small1_r;

    // Stage 2 signals and registers
    logic [AW-1:0]        sum_s;
    logic                 v2_r, sign2_r, nan2_r, inf2_r, infs2_r, zs2_r;
    logic [EXP_W-1:0]     exp2_r;
    logic [AW-1:0]        sum2_r;

    // Stage 3 signals
    logic [LZW-1:0]       lz_s;
    logic [SW-1:0]        norm_s;
    logic signed [EW-1:0] exp_base_s, exp_n_s, exp_f_s;
    logic                 rnd_up_s;
    logic [MAN_W+1:0]     mant_rnd_s;
    logic [MAN_W-1:0]     frac_s;
    logic [W-1:0]         res_s;
    logic                 ovf_s, unf_s, inv_s;

    // Output registers
    logic                 out_valid_r, ovf_r, unf_r, inv_r;
    logic [W-1:0]         s_r;

    assign en_s     = !out_valid_r || out_ready;
    assign in_ready = en_s;

    assign a_sign_s = a[W-1];
    assign b_sign_s = b[W-1] ^ sub;
    assign a_exp_s  = a[W-2:MAN_W];
    assign b_exp_s  = b[W-2:MAN_W];
    assign a_man_s  = a[MAN_W-1:0];
    assign b_man_s  = b[MAN_W-1:0];
    assign a_zero_s = (a_exp_s == {EXP_W{1'b0}});
    assign b_zero_s = (b_exp_s == {EXP_W{1'b0}});
    assign a_inf_s  = (a_exp_s == {EXP_W{1'b1}}) && (a_man_s == {MAN_W{1'b0}});
    assign b_inf_s  = (b_exp_s == {EXP_W{1'b1}}) && (b_man_s == {MAN_W{1'b0}});
    assign a_nan_s  = (a_exp_s == {EXP_W{1'b1}}) && (a_man_s != {MAN_W{1'b0}});
    assign b_nan_s  = (b_exp_s == {EXP_W{1'b1}}) && (b_man_s != {MAN_W{1'b0}});
    // Denormals count as zero, so their magnitude is forced to zero before the swap.
    assign a_mag_s  = a_zero_s ? {(W-1){1'b0}} : a[W-2:0];
    assign b_mag_s  = b_zero_s ? {(W-1){1'b0}} : b[W-2:0];

    // Stage 1 datapath: classify, order by magnitude and align the smaller operand
    always_comb begin
        big_sign_s   = 1'b0;
        small_sign_s = 1'b0;
        big_exp_s    = {EXP_W{1'b0}};
        small_exp_s  = {EXP_W{1'b0}};
        big_sig_s    = {(MAN_W+1){1'b0}};
        small_sig_s  = {(MAN_W+1){1'b0}};
        if (a_mag_s >= b_mag_s) begin
            big_sign_s   = a_sign_s;
            small_sign_s = b_sign_s;
            big_exp_s    = a_exp_s;
            small_exp_s  = b_exp_s;
            big_sig_s    = a_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, a_man_s};
            small_sig_s  = b_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, b_man_s};
        end else begin
            big_sign_s   = b_sign_s;
            small_sign_s = a_sign_s;
            big_exp_s    = b_exp_s;
            small_exp_s  = a_exp_s;
            big_sig_s    = b_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, b_man_s};
            small_sig_s  = a_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, a_man_s};
        end
        shift_s      = big_exp_s - small_exp_s;
        small_full_s = {small_sig_s, 3'b000};
        if (32'(shift_s) >= SHIFT_MAX) begin
            small_al_s = {{(SW-1){1'b0}}, |small_sig_s};
        end else begin
            small_al_s    = small_full_s >> shift_s;
            small_al_s[0] = small_al_s[0] | (|(small_full_s & ~({SW{1'b1}} << shift_s)));
        end
        nan_s       = a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_sign_s != b_sign_s));
        inf_s       = (a_inf_s || b_inf_s) && !nan_s;
        inf_sign_s  = a_inf_s ? a_sign_s : b_sign_s;
        zero_sign_s = a_zero_s && b_zero_s && a_sign_s && b_sign_s;
    end

    // Stage 1 register: aligned operands and special-case classification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            sign1_r  <= 1'b0;
            esub1_r  <= 1'b0;
            nan1_r   <= 1'b0;
            inf1_r   <= 1'b0;
            infs1_r  <= 1'b0;
            zs1_r    <= 1'b0;
            exp1_r   <= {EXP_W{1'b0}};
            big1_r   <= {SW{1'b0}};
            small1_r <= {SW{1'b0}};
        end else if (en_s) begin
            v1_r     <= in_valid;
            sign1_r  <= big_sign_s;
            esub1_r  <= big_sign_s ^ small_sign_s;
            nan1_r   <= nan_s;
            inf1_r   <= inf_s;
            infs1_r  <= inf_sign_s;
            zs1_r    <= zero_sign_s;
            exp1_r   <= big_exp_s;
            big1_r   <= {big_sig_s, 3'b000};
            small1_r <= small_al_s;
        end
    end

    // Stage 2 datapath: magnitude add or subtract (larger operand is always first)
    always_comb begin
        sum_s = {AW{1'b0}};
        if (esub1_r) begin
            sum_s = {1'b0, big1_r} - {1'b0, small1_r};
        end else begin
            sum_s = {1'b0, big1_r} + {1'b0, small1_r};
        end
    end

    // Stage 2 register: raw significand sum with its exponent and sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            sign2_r <= 1'b0;
            nan2_r  <= 1'b0;
            inf2_r  <= 1'b0;
            infs2_r <= 1'b0;
            zs2_r   <= 1'b0;
            exp2_r  <= {EXP_W{1'b0}};
            sum2_r  <= {AW{1'b0}};
        end else if (en_s) begin
            v2_r    <= v1_r;
            sign2_r <= sign1_r;
            nan2_r  <= nan1_r;
            inf2_r  <= inf1_r;
            infs2_r <= infs1_r;
            zs2_r   <= zs1_r;
            exp2_r  <= exp1_r;
            sum2_r  <= sum_s;
        end
    end

    // Stage 3 datapath: normalise, round to nearest even, apply result rules
    always_comb begin
        lz_s       = lzc(sum2_r[SW-1:0]);
        exp_base_s = $signed({2'b00, exp2_r});
        if (sum2_r[AW-1]) begin
            norm_s  = {sum2_r[AW-1:2], |sum2_r[1:0]};
            exp_n_s = exp_base_s + EXP_ONE;
        end else begin
            norm_s  = sum2_r[SW-1:0] << lz_s;
            exp_n_s = exp_base_s - $signed(EW'(lz_s));
        end
        rnd_up_s   = norm_s[2] && (norm_s[1] || norm_s[0] || norm_s[3]);
        mant_rnd_s = {1'b0, norm_s[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};
        if (mant_rnd_s[MAN_W+1]) begin
            frac_s  = mant_rnd_s[MAN_W:1];
            exp_f_s = exp_n_s + EXP_ONE;
        end else begin
            frac_s  = mant_rnd_s[MAN_W-1:0];
            exp_f_s = exp_n_s;
        end
        ovf_s = 1'b0;
        unf_s = 1'b0;
        inv_s = 1'b0;
        if (nan2_r) begin
            res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            inv_s = 1'b1;
        end else if (inf2_r) begin
            res_s = {infs2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (sum2_r == {AW{1'b0}}) begin
            // Exact cancellation gives +0; only (-0)+(-0) keeps the minus sign.
            res_s = {zs2_r, {(W-1){1'b0}}};
        end else if (exp_f_s >= EXP_INF) begin
            res_s = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_s = 1'b1;
        end else if (exp_f_s <= EXP_ZERO) begin
            res_s = {sign2_r, {(W-1){1'b0}}};
            unf_s = 1'b1;
        end else begin
            res_s = {sign2_r, exp_f_s[EXP_W-1:0], frac_s};
        end
    end

    // Output register: result and flags, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            s_r         <= {W{1'b0}};
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            inv_r       <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= v2_r;
            s_r         <= res_s;
            ovf_r       <= ovf_s;
            unf_r       <= unf_s;
            inv_r       <= inv_s;
        end
    end

    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;
    assign invalid   = inv_r;

endmodule

// File: tb/tb_fpalu_add_pipe.sv
// Bench for fpalu_add_pipe: exact-arithmetic reference model, scoreboard
// compare on every output cycle, plus literal expectations for key vectors.
module tb_fpalu_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic        overflow, underflow, invalid;
    logic [31:0] a, b, s;

    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic        h_overflow, h_underflow, h_invalid;
    logic [15:0] h_a, h_b, h_s;

    int total = 0;
    int bad   = 0;
    int accepts = 0;
    logic [66:0] exq[$];

    always #5 clk = ~clk;

    fpalu_add_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    fpalu_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .s(h_s), .overflow(h_overflow), .underflow(h_underflow), .invalid(h_invalid)
    );

    task automatic chk(input string nm, input logic [66:0] got, input logic [66:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Reference: exact integer sum of the two values scaled by 2^32, then
    // round-to-nearest-even on the exact magnitude. Returns {inv,unf,ovf,s}.
    function automatic logic [66:0] ref_add(input int ew, input int mw,
                                            input logic [63:0] av, input logic [63:0] bv,
                                            input logic flip);
        longint emx, fmask, ea, eb, fa, fb, siga, sigb, emax, va, vb, tot, mag, q, rem, half, e;
        logic sa, sb, sg, na, nb, ia, ib;
        logic [63:0] res;
        int p, sh;
        emx   = (longint'(1) << ew) - 1;
        fmask = (longint'(1) << mw) - 1;
        sa = av[ew+mw];
        sb = bv[ew+mw] ^ flip;
        ea = longint'(av >> mw) & emx;
        eb = longint'(bv >> mw) & emx;
        fa = longint'(av) & fmask;
        fb = longint'(bv) & fmask;
        na = (ea == emx) && (fa != 0);
        nb = (eb == emx) && (fb != 0);
        ia = (ea == emx) && (fa == 0);
        ib = (eb == emx) && (fb == 0);
        res = 64'd0;
        if (na || nb || (ia && ib && sa != sb)) begin
            res = 64'(emx << mw) | 64'(longint'(1) << (mw - 1));
            return {3'b100, res};
        end
        if (ia || ib) begin
            res = 64'(emx << mw);
            res[ew+mw] = ia ? sa : sb;
            return {3'b000, res};
        end
        if (ea == 0 && eb == 0) begin
            res[ew+mw] = sa & sb;
            return {3'b000, res};
        end
        siga = (ea == 0) ? 0 : ((longint'(1) << mw) | fa);
        sigb = (eb == 0) ? 0 : ((longint'(1) << mw) | fb);
        emax = (ea > eb) ? ea : eb;
        va = (emax - ea <= 32) ? (siga << (32 - (emax - ea))) : ((siga != 0) ? 1 : 0);
        vb = (emax - eb <= 32) ? (sigb << (32 - (emax - eb))) : ((sigb != 0) ? 1 : 0);
        if (sa) va = -va;
        if (sb) vb = -vb;
        tot = va + vb;
        if (tot == 0) return 67'd0;
        sg  = (tot < 0);
        mag = sg ? -tot : tot;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        sh = p - mw;
        e  = emax + sh - 32;
        if (sh > 0) begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = mag << (-sh);
        end
        res[ew+mw] = sg;
        if (e >= emx) begin
            res = res | 64'(emx << mw);
            return {3'b001, res};
        end
        if (e <= 0) return {3'b010, res};
        res = res | 64'(e << mw) | 64'(q & fmask);
        return {3'b000, res};
    endfunction

    // Scoreboard: check every valid output against the queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (exq.size() == 0) begin
                chk("idle_out_valid", {66'd0, out_valid}, 67'd0);
            end else if (out_valid) begin
                chk("result", {invalid, underflow, overflow, 32'd0, s}, exq[0]);
                if (out_ready) void'(exq.pop_front());
            end
            if (in_valid && in_ready) begin
                exq.push_back(ref_add(8, 23, {32'd0, a}, {32'd0, b}, sub));
                accepts++;
            end
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        logic acc;
        acc = 1'b0;
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 67'd0, 67'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exq.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 67'(exq.size()), 67'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = 16'd0; h_b = 16'd0; h_sub = 1'b0; h_out_ready = 1'b1;
        #1;
        chk("reset_state", {invalid, underflow, overflow, out_valid, 31'd0, s}, 67'd0);
        chk("reset_in_ready", {66'd0, in_ready}, 67'd1);

        // Pin the model to hand-computed answers
        chk("model_add", ref_add(8, 23, 64'h3F800000, 64'h3F800000, 1'b0), {3'b000, 64'h40000000});
        chk("model_cancel", ref_add(8, 23, 64'h3FC00000, 64'h3FC00000, 1'b1), 67'd0);
        chk("model_negzero", ref_add(8, 23, 64'h80000000, 64'h80000000, 1'b0), {3'b000, 64'h80000000});
        chk("model_rne_even", ref_add(8, 23, 64'h3F800000, 64'h33800000, 1'b0), {3'b000, 64'h3F800000});
        chk("model_rne_odd", ref_add(8, 23, 64'h3F800001, 64'h33800000, 1'b0), {3'b000, 64'h3F800002});
        chk("model_ovf", ref_add(8, 23, 64'h7F7FFFFF, 64'h7F7FFFFF, 1'b0), {3'b001, 64'h7F800000});
        chk("model_inv", ref_add(8, 23, 64'h7F800000, 64'hFF800000, 1'b0), {3'b100, 64'h7FC00000});
        chk("model_half", ref_add(5, 10, 64'h3C00, 64'h3C00, 1'b0), {3'b000, 64'h4000});

        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: presented in cycle 0, visible exactly three edges later
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        h_a = 16'h3C00; h_b = 16'h3C00; h_in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; h_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("latency_early", {66'd0, out_valid}, 67'd0);
        @(posedge clk); #1;
        chk("latency_valid", {66'd0, out_valid}, 67'd1);
        chk("basic_add", {invalid, underflow, overflow, 32'd0, s}, {3'b000, 64'h40000000});
        chk("half_valid", {66'd0, h_out_valid}, 67'd1);
        chk("half_add", {h_invalid, h_underflow, h_overflow, 48'd0, h_s}, {3'b000, 64'h4000});
        chk("half_model", {h_invalid, h_underflow, h_overflow, 48'd0, h_s},
            ref_add(5, 10, {48'd0, h_a}, {48'd0, h_b}, 1'b0));
        @(posedge clk); #1;

        // Directed vectors streamed back-to-back
        send(32'h3FC00000, 32'h3FC00000, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0);
        send(32'h3F800000, 32'h33800000, 1'b0);
        send(32'h3F800001, 32'h33800000, 1'b0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        send(32'h7F800000, 32'hFF800000, 1'b0);
        send(32'h7F800000, 32'h3F800000, 1'b0);
        send(32'h7F800001, 32'h3F800000, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b1);
        send(32'h40400000, 32'h3F800000, 1'b1);
        send(32'h00400000, 32'h3F800000, 1'b0);
        send(32'h00800000, 32'h00800001, 1'b1);
        send(32'h7F7FFFFF, 32'h73000000, 1'b0);
        send(32'h3F800000, 32'hBF800000, 1'b0);
        send(32'h3FC00000, 32'h40200000, 1'b0);
        drain();

        // Backpressure: only three pairs fit while the consumer stalls
        out_ready = 1'b0;
        accepts = 0;
        fork
            begin
                send(32'h40400000, 32'h3F800000, 1'b0);
                send(32'h41200000, 32'h3DCCCCCD, 1'b0);
                send(32'hC0A00000, 32'h40A00000, 1'b1);
                send(32'h3F800000, 32'h3F800000, 1'b1);
                send(32'h42C80000, 32'hC2C60000, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                chk("stall_in_ready", {66'd0, in_ready}, 67'd0);
                chk("stall_accepts", 67'(accepts), 67'd3);
                chk("stall_out_valid", {66'd0, out_valid}, 67'd1);
                repeat (3) @(posedge clk);
                #2;
                chk("stall_hold", {invalid, underflow, overflow, 32'd0, s}, exq[0]);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_accepts", 67'(accepts), 67'd5);

        // Asynchronous reset with results still in flight
        send(32'h3F800000, 32'h3F800000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b0);
        #2 rst_n = 1'b0;
        exq.delete();
        #1;
        chk("async_reset", {invalid, underflow, overflow, out_valid, 31'd0, s}, 67'd0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_idle", {66'd0, out_valid}, 67'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
